// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      ACTIVE = 2'd2
   } oam_dma_state_e;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam int unsigned OAM_LEN      = 160;
   localparam logic [15:0] HIGH_BASE    = 16'hFF00;
   localparam logic [7:0]  ECHO_BASE    = 8'hE0;
   localparam logic [7:0]  LAST_INDEX   = 8'(OAM_LEN - 1);

   // Source pages in echo RAM (E0..FF) alias work RAM 0x2000 lower.
   function automatic logic [7:0] echo_wrap(input logic [7:0] src);
      return (src >= ECHO_BASE) ? (src - 8'h20) : src;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA controller: owns FF46, copies 160 bytes into OAM and gates the
// CPU off the external bus while a copy is running.
module oam_dma
   import oam_dma_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  t_cycle,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_enable,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_data_out,
   output logic [7:0]  cpu_data_in,
   output logic [15:0] bus_addr,
   output logic        bus_enable,
   output logic        bus_write,
   output logic [7:0]  bus_data_out,
   input  logic [7:0]  bus_data_in,
   output logic [7:0]  oam_addr,
   output logic        oam_write,
   output logic [7:0]  oam_data,
   output logic        dma_active
);

   oam_dma_state_e state, state_n;
   logic [7:0] index, index_n;
   logic [7:0] src_reg, src_n;
   // Source page used by the running copy; differs from src_reg only
   // between a restart write and the end of the restart delay M-cycle.
   logic [7:0] cur_src, cur_src_n;
   logic       restart_pend, restart_pend_n;

   logic commit;
   logic ff46_sel;
   logic ff46_wr;
   logic last;

   assign commit   = (t_cycle == 2'd3);
   assign ff46_sel = (cpu_addr == DMA_REG_ADDR);
   assign ff46_wr  = commit & cpu_enable & cpu_write & ff46_sel;
   assign last     = (index == LAST_INDEX);

   assign dma_active = (state == ACTIVE);

   // State and transfer registers, committed at the M-cycle boundary.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         index        <= '0;
         src_reg      <= 8'hFF;
         cur_src      <= 8'hFF;
         restart_pend <= 1'b0;
      end else begin
         state        <= state_n;
         index        <= index_n;
         src_reg      <= src_n;
         cur_src      <= cur_src_n;
         restart_pend <= restart_pend_n;
      end
   end

   // Next-state logic: transitions and index steps only at t_cycle==3.
   always_comb begin
      state_n        = state;
      index_n        = index;
      src_n          = src_reg;
      cur_src_n      = cur_src;
      restart_pend_n = restart_pend;

      if (ff46_wr) begin
         src_n = cpu_data_out;
      end

      if (commit) begin
         unique case (state)
            IDLE: begin
               index_n = '0;
               if (ff46_wr) begin
                  state_n = START;
               end
            end
            START: begin
               // A repeated write keeps us in Start for another M-cycle.
               if (!ff46_wr) begin
                  state_n   = ACTIVE;
                  index_n   = '0;
                  cur_src_n = src_reg;
               end
            end
            ACTIVE: begin
               if (restart_pend) begin
                  // Restart delay M-cycle: one byte copied from the old
                  // source, then the fresh copy begins at index 0.
                  if (ff46_wr) begin
                     if (last) begin
                        state_n        = START;
                        restart_pend_n = 1'b0;
                     end else begin
                        index_n = index + 8'd1;
                     end
                  end else begin
                     index_n        = '0;
                     cur_src_n      = src_reg;
                     restart_pend_n = 1'b0;
                  end
               end else if (ff46_wr) begin
                  // No byte 160 exists, so a restart on the final byte
                  // falls back to an ordinary Start delay.
                  if (last) begin
                     state_n = START;
                  end else begin
                     restart_pend_n = 1'b1;
                     index_n        = index + 8'd1;
                  end
               end else if (last) begin
                  state_n = IDLE;
                  index_n = '0;
               end else begin
                  index_n = index + 8'd1;
               end
            end
            default: begin
               state_n        = IDLE;
               index_n        = '0;
               restart_pend_n = 1'b0;
            end
         endcase
      end
   end

   // Bus ownership mux, CPU gating and OAM write strobe.
   always_comb begin
      bus_addr     = cpu_addr;
      bus_enable   = cpu_enable;
      bus_write    = cpu_write;
      bus_data_out = cpu_data_out;
      cpu_data_in  = bus_data_in;
      oam_write    = 1'b0;
      oam_addr     = index;
      oam_data     = bus_data_in;

      if (state == ACTIVE) begin
         bus_addr   = {echo_wrap(cur_src), index};
         bus_enable = 1'b1;
         bus_write  = 1'b0;
         if (cpu_addr < HIGH_BASE) begin
            cpu_data_in = 8'hFF;
         end
         oam_write = commit & reset;
      end

      if (ff46_sel) begin
         cpu_data_in = src_reg;
         if (state != ACTIVE) begin
            bus_enable = 1'b0;
            bus_write  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  t_cycle;
   logic [15:0] cpu_addr;
   logic        cpu_enable;
   logic        cpu_write;
   logic [7:0]  cpu_data_out;
   logic [7:0]  cpu_data_in;
   logic [15:0] bus_addr;
   logic        bus_enable;
   logic        bus_write;
   logic [7:0]  bus_data_out;
   logic [7:0]  bus_data_in;
   logic [7:0]  oam_addr;
   logic        oam_write;
   logic [7:0]  oam_data;
   logic        dma_active;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   logic        s_oam_write;
   logic [7:0]  s_oam_addr;
   logic [7:0]  s_oam_data;
   logic [15:0] s_bus_addr;
   logic        s_bus_enable;
   logic        s_bus_write;
   logic [7:0]  s_bus_data_out;
   logic [7:0]  s_cpu_data_in;
   logic        s_dma_active;

   oam_dma dut (
      .clk(clk), .reset(reset), .t_cycle(t_cycle),
      .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
      .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
      .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
      .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
      .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data),
      .dma_active(dma_active)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_model(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
   endfunction

   assign bus_data_in = mem_model(bus_addr);

   // One M-cycle with the CPU inputs held; outputs sampled at t_cycle==3.
   task automatic mcycle(input logic en, input logic wr, input logic [15:0] addr,
                         input logic [7:0] data);
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         t_cycle      = 2'(t);
         cpu_enable   = en;
         cpu_write    = wr;
         cpu_addr     = addr;
         cpu_data_out = data;
         #1;
         if (oam_write === 1'b1) wr_count++;
         if (t == 3) begin
            s_oam_write    = oam_write;
            s_oam_addr     = oam_addr;
            s_oam_data     = oam_data;
            s_bus_addr     = bus_addr;
            s_bus_enable   = bus_enable;
            s_bus_write    = bus_write;
            s_bus_data_out = bus_data_out;
            s_cpu_data_in  = cpu_data_in;
            s_dma_active   = dma_active;
         end
      end
   endtask

   task automatic idle_cycle();
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic test_reset();
      logic [7:0] exp_rd;
      reset = 1'b0;
      idle_cycle();
      idle_cycle();
      mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
      checks++;
      if ({s_dma_active, s_oam_write} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00", {s_dma_active, s_oam_write});
      end
      checks++;
      if (s_cpu_data_in !== 8'hFF) begin
         errors++;
         $display("FAIL reset_ff46 got %h exp ff", s_cpu_data_in);
      end
      checks++;
      if (s_bus_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_ff46_bus_en got %b exp 0", s_bus_enable);
      end
      exp_rd = mem_model(16'hC000);
      mcycle(1'b1, 1'b0, 16'hC000, 8'h00);
      checks++;
      if ({s_bus_addr, s_bus_enable, s_bus_write, s_cpu_data_in} !== {16'hC000, 1'b1, 1'b0, exp_rd}) begin
         errors++;
         $display("FAIL reset_mirror got %h %b %b %h exp c000 1 0 %h",
                  s_bus_addr, s_bus_enable, s_bus_write, s_cpu_data_in, exp_rd);
      end
      reset = 1'b1;
      idle_cycle();
   endtask

   task automatic test_idle_passthrough();
      wr_count = 0;
      mcycle(1'b1, 1'b1, 16'hC000, 8'h5A);
      checks++;
      if ({s_bus_addr, s_bus_enable, s_bus_write, s_bus_data_out} !== {16'hC000, 1'b1, 1'b1, 8'h5A}) begin
         errors++;
         $display("FAIL idle_write got %h %b %b %h exp c000 1 1 5a",
                  s_bus_addr, s_bus_enable, s_bus_write, s_bus_data_out);
      end
      mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
      checks++;
      if (s_cpu_data_in !== 8'hFF) begin
         errors++;
         $display("FAIL idle_ff46_read got %h exp ff", s_cpu_data_in);
      end
      checks++;
      if (wr_count !== 0) begin
         errors++;
         $display("FAIL idle_oam_write got %0d exp 0", wr_count);
      end
   endtask

   task automatic test_transfer();
      logic [15:0] ea;
      wr_count = 0;
      mcycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
      checks++;
      if ({s_bus_enable, s_dma_active} !== 2'b00) begin
         errors++;
         $display("FAIL xfer_ff46_wr got %b exp 00", {s_bus_enable, s_dma_active});
      end
      idle_cycle();
      checks++;
      if (s_dma_active !== 1'b0) begin
         errors++;
         $display("FAIL xfer_start_inactive got %b exp 0", s_dma_active);
      end
      for (int i = 0; i < 160; i++) begin
         ea = {8'hC1, 8'(i)};
         case (i)
            10: mcycle(1'b1, 1'b0, 16'hC000, 8'h00);
            11: mcycle(1'b1, 1'b1, 16'h8000, 8'h77);
            12: mcycle(1'b1, 1'b0, 16'hFF85, 8'h00);
            13: mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
            default: idle_cycle();
         endcase
         checks++;
         if ({s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data} !==
             {1'b1, 1'b1, 8'(i), ea, mem_model(ea)}) begin
            errors++;
            $display("FAIL xfer_byte%0d got %b %b %h %h %h exp 1 1 %h %h %h", i,
                     s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data,
                     8'(i), ea, mem_model(ea));
         end
         if (i == 10) begin
            checks++;
            if ({s_cpu_data_in, s_bus_write} !== {8'hFF, 1'b0}) begin
               errors++;
               $display("FAIL gate_low_read got %h %b exp ff 0", s_cpu_data_in, s_bus_write);
            end
         end
         if (i == 11) begin
            checks++;
            if (s_bus_write !== 1'b0) begin
               errors++;
               $display("FAIL gate_low_write got %b exp 0", s_bus_write);
            end
         end
         if (i == 12) begin
            checks++;
            if (s_cpu_data_in !== mem_model(ea)) begin
               errors++;
               $display("FAIL high_read got %h exp %h", s_cpu_data_in, mem_model(ea));
            end
         end
         if (i == 13) begin
            checks++;
            if (s_cpu_data_in !== 8'hC1) begin
               errors++;
               $display("FAIL active_ff46_read got %h exp c1", s_cpu_data_in);
            end
         end
      end
      idle_cycle();
      checks++;
      if (s_dma_active !== 1'b0) begin
         errors++;
         $display("FAIL xfer_end_active got %b exp 0", s_dma_active);
      end
      checks++;
      if (wr_count !== 160) begin
         errors++;
         $display("FAIL xfer_count got %0d exp 160", wr_count);
      end
   endtask

   task automatic test_echo();
      logic [15:0] ea;
      int bad;
      bad = 0;
      mcycle(1'b1, 1'b1, 16'hFF46, 8'hE3);
      idle_cycle();
      for (int i = 0; i < 160; i++) begin
         ea = {8'hC3, 8'(i)};
         if (i == 5) mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
         else idle_cycle();
         checks++;
         if (s_bus_addr !== ea) begin
            errors++;
            if (bad < 4) $display("FAIL echo_addr%0d got %h exp %h", i, s_bus_addr, ea);
            bad++;
         end
         if (i == 5) begin
            checks++;
            if (s_cpu_data_in !== 8'hE3) begin
               errors++;
               $display("FAIL echo_ff46_read got %h exp e3", s_cpu_data_in);
            end
         end
      end
      idle_cycle();
   endtask

   task automatic test_restart();
      logic [15:0] ea;
      wr_count = 0;
      mcycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
      idle_cycle();
      for (int i = 0; i < 50; i++) idle_cycle();
      mcycle(1'b1, 1'b1, 16'hFF46, 8'hD0);
      checks++;
      if ({s_oam_addr, s_bus_addr} !== {8'd50, 16'hC132}) begin
         errors++;
         $display("FAIL restart_cur got %h %h exp 32 c132", s_oam_addr, s_bus_addr);
      end
      mcycle(1'b1, 1'b0, 16'hC000, 8'h00);
      checks++;
      if ({s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data, s_cpu_data_in} !==
          {1'b1, 1'b1, 8'd51, 16'hC133, mem_model(16'hC133), 8'hFF}) begin
         errors++;
         $display("FAIL restart_delay got %b %b %h %h %h %h exp 1 1 33 c133 %h ff",
                  s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data,
                  s_cpu_data_in, mem_model(16'hC133));
      end
      for (int i = 0; i < 160; i++) begin
         ea = {8'hD0, 8'(i)};
         idle_cycle();
         checks++;
         if ({s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data} !==
             {1'b1, 1'b1, 8'(i), ea, mem_model(ea)}) begin
            errors++;
            $display("FAIL restart_byte%0d got %b %b %h %h %h exp 1 1 %h %h %h", i,
                     s_dma_active, s_oam_write, s_oam_addr, s_bus_addr, s_oam_data,
                     8'(i), ea, mem_model(ea));
         end
      end
      idle_cycle();
      checks++;
      if ({s_dma_active, wr_count} !== {1'b0, 32'(212)}) begin
         errors++;
         $display("FAIL restart_total got %b %0d exp 0 212", s_dma_active, wr_count);
      end
   endtask

   task automatic test_reset_mid();
      wr_count = 0;
      mcycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
      idle_cycle();
      for (int i = 0; i < 80; i++) idle_cycle();
      reset = 1'b0;
      idle_cycle();
      checks++;
      if ({s_dma_active, s_oam_write} !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset_flags got %b exp 00", {s_dma_active, s_oam_write});
      end
      checks++;
      if (wr_count !== 80) begin
         errors++;
         $display("FAIL mid_reset_count got %0d exp 80", wr_count);
      end
      reset = 1'b1;
      mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
      checks++;
      if (s_cpu_data_in !== 8'hFF) begin
         errors++;
         $display("FAIL mid_reset_ff46 got %h exp ff", s_cpu_data_in);
      end
      mcycle(1'b1, 1'b0, 16'hC000, 8'h00);
      checks++;
      if ({s_bus_addr, s_bus_enable, s_cpu_data_in} !== {16'hC000, 1'b1, mem_model(16'hC000)}) begin
         errors++;
         $display("FAIL mid_reset_pass got %h %b %h exp c000 1 %h",
                  s_bus_addr, s_bus_enable, s_cpu_data_in, mem_model(16'hC000));
      end
      for (int i = 0; i < 4; i++) idle_cycle();
      checks++;
      if (wr_count !== 80) begin
         errors++;
         $display("FAIL mid_reset_quiet got %0d exp 80", wr_count);
      end
   endtask

   initial begin
      reset        = 1'b0;
      t_cycle      = 2'd0;
      cpu_addr     = 16'h0000;
      cpu_enable   = 1'b0;
      cpu_write    = 1'b0;
      cpu_data_out = 8'h00;
      test_reset();
      test_idle_passthrough();
      test_transfer();
      test_echo();
      test_restart();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
